wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the user-project memory path.
- Master 0 is the CPU Wishbone slave path (firmware accesses). Master 1 is the matrix-multiply DMA engine (A/B reads, Y writes).
- Grants exactly one single-beat transaction at a time to the shared memory slave, and routes ack/read data back to the granted master only.

Parameters:
- pDATA_WIDTH, 32, data bus width.
- pADDR_WIDTH, 32, address bus width.
- FIXED_PRIO, 0. 0 = round-robin; 1 = master 0 always wins ties.
- TIMEOUT_CYCLES, 255. Watchdog limit; used only with the optional feature.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset (see Behaviour)
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_sel_i  in  4  byte select
- m0_adr_i  in  pADDR_WIDTH  address
- m0_dat_i  in  pDATA_WIDTH  write data
- m0_ack_o  out  1  ack to master 0
- m0_dat_o  out  pDATA_WIDTH  read data to master 0
- m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_dat_o: same as m0_*, for master 1 (DMA)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
- s_sel_o  out  4  byte select
- s_adr_o  out  pADDR_WIDTH  address
- s_dat_o  out  pDATA_WIDTH  write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  pDATA_WIDTH  slave read data
- grant_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1. 00 when idle.

Behaviour:
- Clock wb_clk_i. Reset wb_rst_i, asynchronous, active-high.
- Reset state: IDLE, last_grant = 1 (so m0 wins the first tie). All outputs 0.
- Request definition: reqN = mN_cyc_i & mN_stb_i.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Only req0 -> GNT0. Only req1 -> GNT1. Neither -> stay IDLE.
  - Both, FIXED_PRIO=1 -> GNT0.
  - Both, FIXED_PRIO=0 -> grant the master that is not last_grant.
  - last_grant updates on entry to GNTx.
- Arbitration latency: grant is registered, so the slave sees the request one cycle after reqN first rises.
- GNTx mux: s_cyc/stb/we/sel/adr/dat_o are a combinational mux of live master-x inputs. Outputs are 0 in IDLE.
- Ack routing:
  - mx_ack_o = s_ack_i in GNTx, same cycle.
  - mx_dat_o = s_dat_i while in GNTx, else 0.
  - The non-granted master sees ack = 0 and dat = 0.
- GNTx exit on s_ack_i -> IDLE. There is one mandatory IDLE cycle between transactions, so back-to-back grants cost 2 cycles minimum plus slave latency.
- Abort: if reqx deasserts in GNTx without s_ack_i -> IDLE next cycle, no ack issued. A late s_ack_i arriving in IDLE is dropped.
- Simultaneous abort and s_ack_i in the same cycle: ack is still forwarded (combinational), then -> IDLE.
- Grant is held for the full transaction; no preemption. A stalled slave blocks the other master indefinitely unless the optional feature is built.
- Reset mid-transaction: slave signals drop to 0 asynchronously; no ack issued.

Optional Feature:
- Macro: WB_MEM_ARB_TIMEOUT_EN.
- With the macro:
  - An 8+ bit watchdog counts cycles in GNTx, cleared on entry.
  - When the count reaches TIMEOUT_CYCLES without s_ack_i: the arbiter asserts mx_ack_o for exactly one cycle with mx_dat_o = 32'hDEAD_BEEF, drops s_cyc_o/s_stb_o, and returns to IDLE.
  - If s_ack_i arrives in the same cycle as the timeout, the real ack and data win.
- Without the macro: no counter, no timeout; a stalled slave holds the grant forever.

Test Plan:
- m0 read alone, adr 0x3800_0010; slave acks 2 cycles after s_stb_o with 0x1234_5678 -> m0_ack_o one cycle with m0_dat_o=0x1234_5678; m1_ack_o stays 0; grant_o 01 then 00.
- m0 and m1 held requesting continuously, FIXED_PRIO=0, slave acks immediately -> grant order m0, m1, m0, m1, with an IDLE cycle between each.
- Same stimulus, FIXED_PRIO=1 -> m0 granted every time; m1 starves while req0 stays high.
- m1 write to 0x3800_0100 data 0xA5A5_A5A5, slave stalls 10 cycles; m0 requests meanwhile -> s_* stay on m1 values; m0 is granted only after the ack plus the IDLE cycle.
- m1 drops stb mid-grant with no ack -> IDLE next cycle, no m1_ack_o; a late s_ack_i one cycle later reaches neither master.
- WB_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks an m0 read -> m0_ack_o at cycle 16 of the grant with data 0xDEAD_BEEF; a following m1 request is served normally.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave single-beat Wishbone arbiter for the user-project memory path.
// Optional watchdog enabled by defining WB_MEM_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
    parameter int pDATA_WIDTH    = 32,
    parameter int pADDR_WIDTH    = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [3:0]             m0_sel_i,
    input  logic [pADDR_WIDTH-1:0] m0_adr_i,
    input  logic [pDATA_WIDTH-1:0] m0_dat_i,
    output logic                   m0_ack_o,
    output logic [pDATA_WIDTH-1:0] m0_dat_o,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [3:0]             m1_sel_i,
    input  logic [pADDR_WIDTH-1:0] m1_adr_i,
    input  logic [pDATA_WIDTH-1:0] m1_dat_i,
    output logic                   m1_ack_o,
    output logic [pDATA_WIDTH-1:0] m1_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [3:0]             s_sel_o,
    output logic [pADDR_WIDTH-1:0] s_adr_o,
    output logic [pDATA_WIDTH-1:0] s_dat_o,
    input  logic                   s_ack_i,
    input  logic [pDATA_WIDTH-1:0] s_dat_i,
    output logic [1:0]             grant_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [pDATA_WIDTH-1:0] TIMEOUT_DATA = pDATA_WIDTH'(32'hDEAD_BEEF);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state, next_state;
    logic   last_grant;   // 1: master 1 was granted most recently
    logic   req0, req1;
    logic   timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GNT0) last_grant <= 1'b0;
            if (state == IDLE && next_state == GNT1) last_grant <= 1'b1;
        end
    end

`ifdef WB_MEM_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wd_cnt;

    // wd_cnt holds the number of grant cycles already elapsed, so the
    // TIMEOUT_CYCLES-th grant cycle is the one that fires.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)           wd_cnt <= '0;
        else if (state == IDLE) wd_cnt <= '0;
        else                    wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (state != IDLE) && !s_ack_i && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        next_state = state;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        m0_ack_o   = 1'b0;
        m0_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_dat_o   = '0;
        grant_o    = 2'b00;
        unique case (state)
            IDLE: begin
                if (req0 && req1)
                    next_state = (FIXED_PRIO != 0 || last_grant) ? GNT0 : GNT1;
                else if (req0)
                    next_state = GNT0;
                else if (req1)
                    next_state = GNT1;
            end
            GNT0: begin
                grant_o  = 2'b01;
                s_cyc_o  = m0_cyc_i & ~timeout;
                s_stb_o  = m0_stb_i & ~timeout;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | timeout;
                m0_dat_o = timeout ? TIMEOUT_DATA : s_dat_i;
                if (s_ack_i || !req0 || timeout) next_state = IDLE;
            end
            GNT1: begin
                grant_o  = 2'b10;
                s_cyc_o  = m1_cyc_i & ~timeout;
                s_stb_o  = m1_stb_i & ~timeout;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | timeout;
                m1_dat_o = timeout ? TIMEOUT_DATA : s_dat_i;
                if (s_ack_i || !req1 || timeout) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: a round-robin and a fixed-priority instance share stimulus.
// Timeout checks apply when WB_MEM_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;

    logic        rr_m0_ack, rr_m1_ack, rr_s_cyc, rr_s_stb, rr_s_we;
    logic [31:0] rr_m0_dat, rr_m1_dat, rr_s_adr, rr_s_dat;
    logic [3:0]  rr_s_sel;
    logic [1:0]  rr_grant;
    logic        fp_m0_ack, fp_m1_ack, fp_s_cyc, fp_s_stb, fp_s_we;
    logic [31:0] fp_m0_dat, fp_m1_dat, fp_s_adr, fp_s_dat;
    logic [3:0]  fp_s_sel;
    logic [1:0]  fp_grant;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.pDATA_WIDTH(32), .pADDR_WIDTH(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) dut_rr (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(rr_m0_ack), .m0_dat_o(rr_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(rr_m1_ack), .m1_dat_o(rr_m1_dat),
        .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_we_o(rr_s_we), .s_sel_o(rr_s_sel),
        .s_adr_o(rr_s_adr), .s_dat_o(rr_s_dat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .grant_o(rr_grant)
    );

    wb_mem_arbiter #(.pDATA_WIDTH(32), .pADDR_WIDTH(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(16)) dut_fp (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(fp_m0_ack), .m0_dat_o(fp_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(fp_m1_ack), .m1_dat_o(fp_m1_dat),
        .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we), .s_sel_o(fp_s_sel),
        .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .grant_o(fp_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rr_exp [8];
        logic [1:0] fp_exp [8];
        rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        fp_exp = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

        rst = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = 32'h3800_0010; m0_wdat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
        s_ack = 1'b0; s_rdat = '0;
        #12;
        // reset state, with a request pending
        check("rst grant", 32'(rr_grant), 32'h0);
        check("rst s_cyc", 32'(rr_s_cyc), 32'h0);
        check("rst s_adr", rr_s_adr, 32'h0);
        check("rst m0_ack", 32'(rr_m0_ack), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: m0 read alone, ack two cycles after stb
        m0_cyc = 1'b1; m0_stb = 1'b1;
        #1;
        check("t1 idle grant", 32'(rr_grant), 32'h0);
        step();
        check("t1 grant", 32'(rr_grant), 32'h1);
        check("t1 s_stb", 32'(rr_s_stb), 32'h1);
        check("t1 s_adr", rr_s_adr, 32'h3800_0010);
        check("t1 s_we", 32'(rr_s_we), 32'h0);
        check("t1 s_sel", 32'(rr_s_sel), 32'hF);
        check("t1 m0_ack c1", 32'(rr_m0_ack), 32'h0);
        step();
        check("t1 m0_ack c2", 32'(rr_m0_ack), 32'h0);
        step();
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        #1;
        check("t1 m0_ack", 32'(rr_m0_ack), 32'h1);
        check("t1 m0_dat", rr_m0_dat, 32'h1234_5678);
        check("t1 m1_ack", 32'(rr_m1_ack), 32'h0);
        check("t1 m1_dat", rr_m1_dat, 32'h0);
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0; s_rdat = '0;
        #1;
        check("t1 grant after", 32'(rr_grant), 32'h0);
        check("t1 m0_ack after", 32'(rr_m0_ack), 32'h0);

        // 2: both request continuously, slave acks immediately
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h3800_0020;
        s_ack = 1'b1; s_rdat = 32'hCAFE_0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("t2 rr grant %0d", i), 32'(rr_grant), 32'(rr_exp[i]));
            check($sformatf("t2 fp grant %0d", i), 32'(fp_grant), 32'(fp_exp[i]));
            check($sformatf("t2 rr m1_ack %0d", i), 32'(rr_m1_ack), (rr_exp[i] == 2'b10) ? 32'h1 : 32'h0);
            check($sformatf("t2 fp m1_ack %0d", i), 32'(fp_m1_ack), 32'h0);
            @(posedge clk);
        end
        #1;
        s_ack = 1'b0;
        step();
        check("t2 pre-reset grant", 32'(rr_grant), 32'h1);
        rst = 1'b1;
        #1;
        check("t2 async rst s_cyc", 32'(rr_s_cyc), 32'h0);
        check("t2 async rst grant", 32'(rr_grant), 32'h0);
        check("t2 async rst fp s_stb", 32'(fp_s_stb), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // 3: m1 write stalled 10 cycles while m0 waits
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF;
        m1_adr = 32'h3800_0100; m1_wdat = 32'hA5A5_A5A5;
        #1;
        check("t3 idle grant", 32'(rr_grant), 32'h0);
        step();
        check("t3 s_we", 32'(rr_s_we), 32'h1);
        check("t3 s_dat", rr_s_dat, 32'hA5A5_A5A5);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h3800_0010; m0_we = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            check($sformatf("t3 stall adr %0d", c), rr_s_adr, 32'h3800_0100);
            check($sformatf("t3 stall grant %0d", c), 32'(rr_grant), 32'h2);
            check($sformatf("t3 stall m0_ack %0d", c), 32'(rr_m0_ack), 32'h0);
            @(posedge clk);
        end
        #1;
        s_ack = 1'b1;
        #1;
        check("t3 m1_ack", 32'(rr_m1_ack), 32'h1);
        check("t3 m0_ack at m1 ack", 32'(rr_m0_ack), 32'h0);
        step();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
        #1;
        check("t3 idle gap grant", 32'(rr_grant), 32'h0);
        check("t3 idle gap s_cyc", 32'(rr_s_cyc), 32'h0);
        step();
        check("t3 m0 grant", 32'(rr_grant), 32'h1);
        check("t3 m0 s_adr", rr_s_adr, 32'h3800_0010);
        s_ack = 1'b1; s_rdat = 32'h1111_2222;
        #1;
        check("t3 m0_dat", rr_m0_dat, 32'h1111_2222);
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0; s_rdat = '0;
        #1;
        check("t3 end grant", 32'(rr_grant), 32'h0);

        // 4: m1 aborts, late ack dropped; then abort coinciding with ack
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h3800_0200;
        step();
        check("t4 grant", 32'(rr_grant), 32'h2);
        m1_stb = 1'b0;
        #1;
        check("t4 abort m1_ack", 32'(rr_m1_ack), 32'h0);
        step();
        check("t4 abort grant", 32'(rr_grant), 32'h0);
        s_ack = 1'b1; s_rdat = 32'h7777_7777;
        #1;
        check("t4 late m0_ack", 32'(rr_m0_ack), 32'h0);
        check("t4 late m1_ack", 32'(rr_m1_ack), 32'h0);
        check("t4 late m1_dat", rr_m1_dat, 32'h0);
        step();
        s_ack = 1'b0; m1_stb = 1'b1;
        step();
        check("t4b grant", 32'(rr_grant), 32'h2);
        m1_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'h3333_4444;
        #1;
        check("t4b m1_ack", 32'(rr_m1_ack), 32'h1);
        check("t4b m1_dat", rr_m1_dat, 32'h3333_4444);
        step();
        m1_cyc = 1'b0; s_ack = 1'b0; s_rdat = '0;
        #1;
        check("t4b grant after", 32'(rr_grant), 32'h0);

        // 5: slave never acks an m0 read
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h3800_0010;
        step();
`ifdef WB_MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 15; c++) begin
            check($sformatf("t5 wait m0_ack %0d", c), 32'(rr_m0_ack), 32'h0);
            check($sformatf("t5 wait s_stb %0d", c), 32'(rr_s_stb), 32'h1);
            step();
        end
        check("t5 timeout m0_ack", 32'(rr_m0_ack), 32'h1);
        check("t5 timeout m0_dat", rr_m0_dat, 32'hDEAD_BEEF);
        check("t5 timeout s_cyc", 32'(rr_s_cyc), 32'h0);
        check("t5 timeout s_stb", 32'(rr_s_stb), 32'h0);
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h3800_0300;
        #1;
        check("t5 idle grant", 32'(rr_grant), 32'h0);
        check("t5 idle m0_ack", 32'(rr_m0_ack), 32'h0);
        step();
        check("t5 m1 grant", 32'(rr_grant), 32'h2);
        s_ack = 1'b1; s_rdat = 32'h55AA_55AA;
        #1;
        check("t5 m1_ack", 32'(rr_m1_ack), 32'h1);
        check("t5 m1_dat", rr_m1_dat, 32'h55AA_55AA);
        step();
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        #1;
        check("t5 end grant", 32'(rr_grant), 32'h0);
`else
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("t5 hold grant %0d", c), 32'(rr_grant), 32'h1);
            check($sformatf("t5 hold m0_ack %0d", c), 32'(rr_m0_ack), 32'h0);
            step();
        end
        rst = 1'b1;
        #1;
        check("t5 async rst s_stb", 32'(rr_s_stb), 32'h0);
        check("t5 async rst grant", 32'(rr_grant), 32'h0);
        check("t5 async rst m0_ack", 32'(rr_m0_ack), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
